// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, default
// frame/baud parameters and the oversampling constant.
package uart_pkg;

    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int BAUD_DIV_DEF = 326;
    localparam int OVERSAMPLE   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Counter width for a modulus n, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle s_tick every BAUD_DIV clk cycles,
// restarted from zero while clr is high.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
);

    localparam int             C_W   = cnt_width(BAUD_DIV);
    localparam logic [C_W-1:0] C_MAX = C_W'(BAUD_DIV - 1);

    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;

    // The tick is decoded from the counter so the first tick after a clear
    // lands exactly BAUD_DIV cycles later, for any divider including 1.
    always_comb begin
        cnt_d  = cnt_q;
        s_tick = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == C_MAX) begin
            cnt_d  = '0;
            s_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + C_W'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter FSM: start bit, DBIT data bits LSB first, optional even
// parity bit (define UART_TX_PARITY_EN), then SB_TICK ticks of stop level.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int S_W = cnt_width((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int N_W = cnt_width(DBIT);

    localparam logic [S_W-1:0] BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] DATA_LAST = N_W'(DBIT - 1);

    tx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            s_tick;
    logic            clr_s;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    // The divider idles at zero so every accepted frame starts tick-aligned.
    assign clr_s = (state_q == ST_IDLE);

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .s_tick(s_tick)
    );

    // Next-state, counters and next line level; tx follows state_d so the
    // registered line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A request seen during the done pulse waits one cycle.
                if (tx_start && !done_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = din;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick && (s_q == BIT_LAST)) begin
                    state_d = ST_DATA;
                    s_d     = '0;
                end else if (s_tick) begin
                    s_d = s_q + S_W'(1);
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (s_tick && (s_q == BIT_LAST)) begin
                    s_d = '0;
                    b_d = b_q >> 1;
                    if (n_q == DATA_LAST) begin
                        n_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        n_d = n_q + N_W'(1);
                    end
                end else if (s_tick) begin
                    s_d = s_q + S_W'(1);
                end else begin
                    s_d = s_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick && (s_q == BIT_LAST)) begin
                    state_d = ST_STOP;
                    s_d     = '0;
                end else if (s_tick) begin
                    s_d = s_q + S_W'(1);
                end else begin
                    s_d = s_q;
                end
            end
`endif
            ST_STOP: begin
                if (s_tick && (s_q == STOP_LAST)) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    done_d  = 1'b1;
                end else if (s_tick) begin
                    s_d = s_q + S_W'(1);
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with BAUD_DIV=2 (32 clk cycles per bit);
// a second instance uses SB_TICK=32. Honours UART_TX_PARITY_EN if defined.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BIT_CYC = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] din_a, din_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int   sel = 0;
    logic cur_tx, cur_busy, cur_done;

    logic tx_log   [0:1023];
    logic busy_log [0:1023];
    int   done_at;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign cur_tx   = (sel == 0) ? tx_a   : tx_b;
    assign cur_busy = (sel == 0) ? busy_a : busy_b;
    assign cur_done = (sel == 0) ? done_a : done_b;

    uart_tx_engine #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(2)) dut (
        .clk(clk), .reset(reset), .tx_start(start_a), .din(din_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    uart_tx_engine #(.DBIT(8), .SB_TICK(32), .BAUD_DIV(2)) dut_sb2 (
        .clk(clk), .reset(reset), .tx_start(start_b), .din(din_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] d);
        if (sel == 0) begin
            start_a = s;
            din_a   = d;
        end else begin
            start_b = s;
            din_b   = d;
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int j);
        if (j == 0)                 return 1'b0;
        else if (j <= 8)            return d[j-1];
        else if (j == 9 && PB == 1) return ^d;
        else                        return 1'b1;
    endfunction

    // mode 0: single pulse, 1: tx_start held, 2: re-pulse and din=00 mid-DATA
    task automatic run_frame(input logic [7:0] d, input int mode);
        int c;
        for (int k = 0; k < 1024; k++) begin
            tx_log[k]   = 1'bx;
            busy_log[k] = 1'bx;
        end
        repeat (3) step();
        drive(1'b1, d);
        step();
        if (mode != 1) drive(1'b0, d);
        done_at = -1;
        c = 0;
        while (done_at < 0 && c < 1024) begin
            tx_log[c]   = cur_tx;
            busy_log[c] = cur_busy;
            if (cur_done) begin
                done_at = c;
            end else begin
                if (mode == 2 && c == 100) drive(1'b1, 8'h00);
                else if (mode == 2 && c == 101) drive(1'b0, 8'h00);
                step();
                c++;
            end
        end
        check("done_seen", (done_at >= 0) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input int sb_cyc);
        int len;
        int cnt;
        len = BIT_CYC * (9 + PB) + sb_cyc;
        check({name, "_len"}, done_at, len);
        for (int j = 0; j < 9 + PB; j++) begin
            cnt = 0;
            for (int k = BIT_CYC * j; k < BIT_CYC * (j + 1); k++)
                if (tx_log[k] === exp_bit(d, j)) cnt++;
            check($sformatf("%s_bit%0d", name, j), cnt, BIT_CYC);
        end
        cnt = 0;
        for (int k = BIT_CYC * (9 + PB); k < len; k++)
            if (tx_log[k] === 1'b1) cnt++;
        check({name, "_stop"}, cnt, sb_cyc);
        check({name, "_busy_end"}, (busy_log[len-1] === 1'b1) ? 1 : 0, 1);
        check({name, "_idle_done"}, (busy_log[len] === 1'b0 && tx_log[len] === 1'b1) ? 1 : 0, 1);
    endtask

    initial begin
        int bad;
        int c;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        din_a   = 8'h00;
        din_b   = 8'h00;
        repeat (2) step();
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_tx_sb2", tx_b, 1);
        reset = 1'b0;
        repeat (5) step();
        check("idle_tx", tx_a, 1);
        check("idle_busy", busy_a, 0);

        run_frame(8'h55, 0);
        check_frame("f55", 8'h55, 16 * 2);
        step();
        check("done_pulse_width", cur_done, 0);

        run_frame(8'hA5, 2);
        check_frame("fA5", 8'hA5, 16 * 2);
        bad = 0;
        repeat (400) begin
            step();
            if (cur_tx !== 1'b1 || cur_busy !== 1'b0) bad++;
        end
        check("no_second_frame", bad, 0);

        run_frame(8'h07, 0);
        check_frame("f07", 8'h07, 16 * 2);
        run_frame(8'h03, 0);
        check_frame("f03", 8'h03, 16 * 2);

        run_frame(8'h55, 1);
        check_frame("hold", 8'h55, 16 * 2);
        check("b2b_done_tx", cur_tx, 1);
        step();
        check("b2b_gap_tx", cur_tx, 1);
        check("b2b_gap_busy", cur_busy, 0);
        step();
        check("b2b_restart_tx", cur_tx, 0);
        check("b2b_restart_busy", cur_busy, 1);
        drive(1'b0, 8'h55);
        c = 0;
        while (!cur_done && c < 1000) begin
            step();
            c++;
        end
        check("b2b_second_done", cur_done, 1);

        repeat (3) step();
        drive(1'b1, 8'h00);
        step();
        drive(1'b0, 8'h00);
        repeat (100) step();
        check("pre_rst_busy", cur_busy, 1);
        check("pre_rst_tx", cur_tx, 0);
        reset = 1'b1;
        #1;
        check("midrst_tx", cur_tx, 1);
        check("midrst_busy", cur_busy, 0);
        check("midrst_done", cur_done, 0);
        step();
        step();
        reset = 1'b0;
        bad = 0;
        repeat (400) begin
            step();
            if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);

        sel = 1;
        run_frame(8'h55, 0);
        check_frame("sb32", 8'h55, 32 * 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, number of oversample ticks in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have parameter BAUD_DIV, default 326, number of clk cycles per oversample tick (50 MHz / (9600 x 16)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tx_start, input, 1 bit: request to send din; sampled only in IDLE.
REQ-007 SHALL have port din, input, DBIT bits: byte to transmit, captured when tx_start is accepted.
REQ-008 SHALL have port tx, output, 1 bit: registered serial line, idle high.
REQ-009 SHALL have port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port tx_done_tick, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 SHALL, in IDLE with tx_start=1, capture din into a shift register, clear the tick counter and baud divider, and enter START; tx goes 0 on the next clk edge.
REQ-013 SHALL hold each of START, DATA-bit and PARITY for exactly 16 ticks, and STOP for exactly SB_TICK ticks, each tick being BAUD_DIV clk cycles.
REQ-014 SHALL send data bits LSB first, shifting the register right once per completed bit, and use a bit counter of width clog2(DBIT) that leaves DATA after bit DBIT-1.
REQ-015 SHALL drive tx high in STOP and IDLE.
REQ-016 SHALL assert tx_done_tick for one cycle, in the same cycle that STOP exits to IDLE.
REQ-017 SHALL ignore tx_start outside IDLE; din changes during a frame SHALL NOT affect the frame.
REQ-018 SHALL not accept a tx_start asserted in the tx_done_tick cycle; the request is accepted on the following cycle if tx_start is still high (earliest back-to-back spacing: 1 idle cycle).
REQ-019 SHALL give a frame duration, from acceptance to tx_done_tick, of (16*(1+DBIT[+1]) + SB_TICK) * BAUD_DIV cycles, with +1 only when parity is enabled.
REQ-020 SHALL make the tick counter and baud divider wrap to 0 on each bit boundary, with no cumulative drift.

Reset
REQ-021 SHALL, on reset assertion and regardless of state (mid-frame included), immediately force: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, shift register=0, all counters=0.
REQ-022 SHALL, after reset deassertion, not begin a frame until the first clk edge with tx_start=1.

Configuration
REQ-023 SHALL, when macro UART_TX_PARITY_EN is defined, insert state PARITY between DATA and STOP, driving the even parity (XOR of the captured din) for 16 ticks.
REQ-024 SHALL, without UART_TX_PARITY_EN, omit PARITY, so DATA goes directly to STOP and no parity logic is synthesized.

Structure
REQ-025 SHALL define the FSM state encoding, the default values of DBIT/SB_TICK/BAUD_DIV and the OVERSAMPLE=16 constant in shared package uart_pkg.
REQ-026 SHALL instantiate sub-module uart_baud_gen (BAUD_DIV counter, one-cycle s_tick output, synchronous clear input) for tick generation.

Verification
REQ-027 SHALL cover, with BAUD_DIV=2 and no parity: tx_start with din=8'h55 -> tx reads 0,1,0,1,0,1,0,1,0,1 with each bit 32 cycles wide, and tx_done_tick exactly 320 cycles after acceptance.
REQ-028 SHALL cover: din=8'hA5 held, tx_start pulsed again in DATA and din changed to 8'h00 -> transmitted bits remain 1,0,1,0,0,1,0,1 and there is no second frame.
REQ-029 SHALL cover: tx_start held high continuously -> consecutive frames separated by exactly 1 idle-high cycle after tx_done_tick.
REQ-030 SHALL cover: reset asserted mid-DATA -> tx=1 and tx_busy=0 in the same cycle, and no tx_done_tick.
REQ-031 SHALL cover, with UART_TX_PARITY_EN and din=8'h07: parity bit 1, frame length 352 cycles; with din=8'h03: parity bit 0.
REQ-032 SHALL cover, with SB_TICK=32: stop bit of 64 cycles (BAUD_DIV=2), and tx_done_tick at cycle 352.
